// File: rtl/bp_update_sched_if.sv
// Update-scheduler bus: resolved-branch updates in, predictor update ports out.
// The scheduler owns the slave side; the branch-resolution/predictor side owns master.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

interface bp_update_sched_if #(
  parameter int GHR_BITS = `BP_GHR_BITS,
  parameter int DEPTH    = 8
);
  localparam int AW = `INST_ADDR_WIDTH;
  localparam int CW = $clog2(DEPTH) + 1;

  logic                flush;
  logic                stall;
  logic                in0_valid,     in1_valid;
  logic [AW-1:0]       in0_pc,        in1_pc;
  logic [AW-1:0]       in0_target,    in1_target;
  logic                in0_taken,     in1_taken;
  logic                in0_is_call,   in1_is_call;
  logic                in0_is_return, in1_is_return;
  logic [GHR_BITS-1:0] in0_hist,      in1_hist;
  logic                in_ready;
  logic                out0_valid,     out1_valid;
  logic [AW-1:0]       out0_pc,        out1_pc;
  logic [AW-1:0]       out0_target,    out1_target;
  logic                out0_taken,     out1_taken;
  logic                out0_is_call,   out1_is_call;
  logic                out0_is_return, out1_is_return;
  logic [GHR_BITS-1:0] out0_hist,      out1_hist;
  logic [CW-1:0]       count;
  logic                overflow_err;

  modport slave (
    input  flush, stall,
    input  in0_valid, in0_pc, in0_target, in0_taken, in0_is_call, in0_is_return, in0_hist,
    input  in1_valid, in1_pc, in1_target, in1_taken, in1_is_call, in1_is_return, in1_hist,
    output in_ready, count, overflow_err,
    output out0_valid, out0_pc, out0_target, out0_taken, out0_is_call, out0_is_return, out0_hist,
    output out1_valid, out1_pc, out1_target, out1_taken, out1_is_call, out1_is_return, out1_hist
  );

  modport master (
    output flush, stall,
    output in0_valid, in0_pc, in0_target, in0_taken, in0_is_call, in0_is_return, in0_hist,
    output in1_valid, in1_pc, in1_target, in1_taken, in1_is_call, in1_is_return, in1_hist,
    input  in_ready, count, overflow_err,
    input  out0_valid, out0_pc, out0_target, out0_taken, out0_is_call, out0_is_return, out0_hist,
    input  out1_valid, out1_pc, out1_target, out1_taken, out1_is_call, out1_is_return, out1_hist
  );
endinterface

// File: rtl/bp_update_sched.sv
// Two-wide in-order queue of resolved-branch updates feeding the predictor's two update ports.
// One-cycle minimum latency; in_ready drops at DEPTH-1 entries, stall holds the drain side.
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef BP_GHR_BITS
`define BP_GHR_BITS 8
`endif

module bp_update_sched #(
  parameter int GHR_BITS = `BP_GHR_BITS,
  parameter int DEPTH    = 8
) (
  input logic               clk,
  input logic               rst,
  bp_update_sched_if.slave  bus
);
  localparam int AW = `INST_ADDR_WIDTH;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [AW-1:0]       pc;
    logic                taken;
    logic [AW-1:0]       target;
    logic [GHR_BITS-1:0] hist;
    logic                is_call;
    logic                is_return;
  } upd_t;

  upd_t          mem_q [DEPTH];
  upd_t          mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          in_ready;
  logic          push0, push1;
  logic [CW-1:0] n_push, n_pop;
  upd_t          in0_upd, in1_upd, head0, head1;
  logic          out0_valid, out1_valid;
  logic          unused_flush;

  // Redirects must not discard training data, so flush is deliberately ignored.
  assign unused_flush = bus.flush;

  always_comb begin
    in0_upd = '{pc: bus.in0_pc, taken: bus.in0_taken, target: bus.in0_target,
                hist: bus.in0_hist, is_call: bus.in0_is_call, is_return: bus.in0_is_return};
    in1_upd = '{pc: bus.in1_pc, taken: bus.in1_taken, target: bus.in1_target,
                hist: bus.in1_hist, is_call: bus.in1_is_call, is_return: bus.in1_is_return};

    // Ready comes from registered occupancy only, so two slots are always free when high.
    in_ready = (count_q <= CW'(DEPTH - 2));
    push0    = in_ready & bus.in0_valid;
    push1    = in_ready & bus.in1_valid;
    n_push   = CW'(push0) + CW'(push1);

    out0_valid = ~bus.stall & (count_q >= CW'(1));
    out1_valid = ~bus.stall & (count_q >= CW'(2));
    n_pop      = CW'(out0_valid) + CW'(out1_valid);

    mem_d = mem_q;
    if (push0) mem_d[wr_ptr_q] = in0_upd;
    if (push1) mem_d[wr_ptr_q + PW'(push0)] = in1_upd;

    wr_ptr_d   = wr_ptr_q + PW'(n_push);
    rd_ptr_d   = rd_ptr_q + PW'(n_pop);
    count_d    = count_q + n_push - n_pop;
    overflow_d = overflow_q | (~in_ready & (bus.in0_valid | bus.in1_valid));

    head0 = out0_valid ? mem_q[rd_ptr_q]           : '0;
    head1 = out1_valid ? mem_q[rd_ptr_q + PW'(1)]  : '0;
  end

  always_comb begin
    bus.in_ready       = in_ready;
    bus.count          = count_q;
    bus.overflow_err   = overflow_q;
    bus.out0_valid     = out0_valid;
    bus.out0_pc        = head0.pc;
    bus.out0_taken     = head0.taken;
    bus.out0_target    = head0.target;
    bus.out0_hist      = head0.hist;
    bus.out0_is_call   = head0.is_call;
    bus.out0_is_return = head0.is_return;
    bus.out1_valid     = out1_valid;
    bus.out1_pc        = head1.pc;
    bus.out1_taken     = head1.taken;
    bus.out1_target    = head1.target;
    bus.out1_hist      = head1.hist;
    bus.out1_is_call   = head1.is_call;
    bus.out1_is_return = head1.is_return;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Payload storage is validated by the pointers, so it carries no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end
endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched: stimulus pushes expected updates into a scoreboard,
// a negedge monitor pops and compares whatever the predictor ports present.
module tb_bp_update_sched;
  localparam int AW = 32;
  localparam int GB = 8;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic          taken;
    logic [AW-1:0] target;
    logic [GB-1:0] hist;
    logic          is_call;
    logic          is_return;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  ent_t sb[$];

  bp_update_sched_if #(.GHR_BITS(GB), .DEPTH(8)) bus();
  bp_update_sched #(.GHR_BITS(GB), .DEPTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic ent_t mk(input logic [AW-1:0] pc, input logic tk, input logic [AW-1:0] tg,
                              input logic [GB-1:0] h, input logic c, input logic r);
    ent_t e;
    e.pc = pc; e.taken = tk; e.target = tg; e.hist = h; e.is_call = c; e.is_return = r;
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_ent(input string name, input ent_t act, input ent_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got pc=%0h tk=%0b tg=%0h h=%0h c=%0b r=%0b expected pc=%0h tk=%0b tg=%0h h=%0h c=%0b r=%0b",
               name, act.pc, act.taken, act.target, act.hist, act.is_call, act.is_return,
               exp.pc, exp.taken, exp.target, exp.hist, exp.is_call, exp.is_return);
    end
  endtask

  // Drive one cycle starting just after a rising edge; acc says the bench expects acceptance.
  task automatic drive(input logic v0, input ent_t e0, input logic v1, input ent_t e1,
                       input bit acc, input bit nobypass);
    bus.in0_valid = v0; bus.in0_pc = e0.pc; bus.in0_taken = e0.taken; bus.in0_target = e0.target;
    bus.in0_hist = e0.hist; bus.in0_is_call = e0.is_call; bus.in0_is_return = e0.is_return;
    bus.in1_valid = v1; bus.in1_pc = e1.pc; bus.in1_taken = e1.taken; bus.in1_target = e1.target;
    bus.in1_hist = e1.hist; bus.in1_is_call = e1.is_call; bus.in1_is_return = e1.is_return;
    if (acc) begin
      if (v0) sb.push_back(e0);
      if (v1) sb.push_back(e1);
    end
    if (nobypass) begin
      #2;
      check("no_bypass", 64'(bus.out0_valid), 64'd0);
    end
    @(posedge clk); #1;
    bus.in0_valid = 1'b0;
    bus.in1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      ent_t a0, a1;
      a0 = mk(bus.out0_pc, bus.out0_taken, bus.out0_target, bus.out0_hist, bus.out0_is_call, bus.out0_is_return);
      a1 = mk(bus.out1_pc, bus.out1_taken, bus.out1_target, bus.out1_hist, bus.out1_is_call, bus.out1_is_return);
      if (bus.out0_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL out0_unexpected: got pc=%0h with empty scoreboard", a0.pc);
        end else check_ent("out0_entry", a0, sb.pop_front());
      end else check_ent("out0_zero", a0, '0);
      if (bus.out1_valid) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL out1_unexpected: got pc=%0h with empty scoreboard", a1.pc);
        end else check_ent("out1_entry", a1, sb.pop_front());
      end else check_ent("out1_zero", a1, '0);
    end
  end

  initial begin
    ent_t z;
    z = '0;
    bus.flush = 1'b0; bus.stall = 1'b0;
    bus.in0_valid = 1'b0; bus.in1_valid = 1'b0;
    bus.in0_pc = '0; bus.in0_taken = 1'b0; bus.in0_target = '0; bus.in0_hist = '0;
    bus.in0_is_call = 1'b0; bus.in0_is_return = 1'b0;
    bus.in1_pc = '0; bus.in1_taken = 1'b0; bus.in1_target = '0; bus.in1_hist = '0;
    bus.in1_is_call = 1'b0; bus.in1_is_return = 1'b0;

    #2;
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_overflow", 64'(bus.overflow_err), 64'd0);
    check("rst_out0_valid", 64'(bus.out0_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single update, one-cycle latency
    drive(1'b1, mk(32'h100, 1'b1, 32'h200, 8'h5, 1'b0, 1'b0), 1'b0, z, 1'b1, 1'b1);
    check("single_count", 64'(bus.count), 64'd1);
    idle(1);
    check("single_drained", 64'(bus.count), 64'd0);

    // Pair order, both drained together
    drive(1'b1, mk(32'h10, 1'b0, 32'h40, 8'h1, 1'b1, 1'b0), 1'b1, mk(32'h14, 1'b1, 32'h80, 8'h2, 1'b0, 1'b1), 1'b1, 1'b0);
    check("pair_count", 64'(bus.count), 64'd2);
    idle(1);
    check("pair_drained", 64'(bus.count), 64'd0);

    // in1-only occupies a single slot
    drive(1'b0, z, 1'b1, mk(32'h20, 1'b1, 32'h24, 8'h7, 1'b0, 1'b0), 1'b1, 1'b0);
    check("in1_only_count", 64'(bus.count), 64'd1);
    idle(1);

    // Fill under stall, overflow, then drain two per cycle
    bus.stall = 1'b1;
    for (int i = 0; i < 4; i++)
      drive(1'b1, mk(32'h1000 + 32'(8*i), 1'b1, 32'h2000 + 32'(i), 8'(i), 1'b0, 1'b0),
            1'b1, mk(32'h1004 + 32'(8*i), 1'b0, 32'h3000 + 32'(i), 8'(i + 16), 1'b0, 1'b1), 1'b1, 1'b0);
    check("fill_count", 64'(bus.count), 64'd8);
    check("fill_in_ready", 64'(bus.in_ready), 64'd0);
    drive(1'b1, mk(32'hdead, 1'b1, 32'hbeef, 8'hff, 1'b1, 1'b1), 1'b0, z, 1'b0, 1'b0);
    check("ovf_err", 64'(bus.overflow_err), 64'd1);
    check("ovf_count", 64'(bus.count), 64'd8);
    bus.stall = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idle(1);
      check("drain_count", 64'(bus.count), 64'(8 - 2*k));
    end

    // Continuous single pushes across pointer wrap
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, mk(32'(4*i), i[0], 32'h500 + 32'(i), 8'(3*i), i[1], i[2]), 1'b0, z, 1'b1, 1'b0);
      check("wrap_count_le8", 64'(bus.count <= 4'd8), 64'd1);
    end
    idle(2);
    check("wrap_drained", 64'(bus.count), 64'd0);

    // Flush leaves queued entries intact
    bus.stall = 1'b1;
    drive(1'b1, mk(32'h700, 1'b1, 32'h710, 8'h11, 1'b0, 1'b0), 1'b1, mk(32'h704, 1'b0, 32'h720, 8'h12, 1'b1, 1'b0), 1'b1, 1'b0);
    drive(1'b1, mk(32'h708, 1'b1, 32'h730, 8'h13, 1'b0, 1'b1), 1'b0, z, 1'b1, 1'b0);
    bus.flush = 1'b1;
    idle(1);
    bus.flush = 1'b0;
    check("flush_count", 64'(bus.count), 64'd3);
    bus.stall = 1'b0;
    idle(2);
    check("flush_drained", 64'(bus.count), 64'd0);

    // Reset mid-operation, asserted between edges
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++)
      drive(1'b1, mk(32'h900 + 32'(8*i), 1'b1, 32'h0, 8'h0, 1'b0, 1'b0),
            1'b1, mk(32'h904 + 32'(8*i), 1'b0, 32'h0, 8'h0, 1'b0, 1'b0), 1'b1, 1'b0);
    check("pre_rst_count", 64'(bus.count), 64'd6);
    check("pre_rst_ovf_sticky", 64'(bus.overflow_err), 64'd1);
    #2;
    rst = 1'b1;
    bus.stall = 1'b0;
    sb.delete();
    #1;
    check("midrst_count", 64'(bus.count), 64'd0);
    check("midrst_in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst_overflow", 64'(bus.overflow_err), 64'd0);
    check("midrst_out0_valid", 64'(bus.out0_valid), 64'd0);
    check("midrst_out1_valid", 64'(bus.out1_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    drive(1'b1, mk(32'h300, 1'b1, 32'h340, 8'h9, 1'b1, 1'b0), 1'b1, mk(32'h304, 1'b0, 32'h380, 8'ha, 1'b0, 1'b1), 1'b1, 1'b1);
    check("post_rst_count", 64'(bus.count), 64'd2);
    idle(2);
    check("post_rst_drained", 64'(bus.count), 64'd0);
    check("sb_empty", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
